// File: rtl/rggen_bit_field_lock_controller_pkg.sv
// Shared lock definitions: state encoding and counter-width helpers,
// kept separate so future lock variants can reuse them.
package rggen_bit_field_lock_controller_pkg;

    typedef enum logic [1:0] {
        LOCK_LOCKED   = 2'b00,
        LOCK_ARMED    = 2'b01,
        LOCK_UNLOCKED = 2'b10
    } lock_state_e;

    function automatic int lock_clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Counter must hold both the key window and the timeout; never below 1 bit.
    function automatic int lock_counter_width(input int key_window, input int timeout);
        int biggest;
        biggest = 2;
        if (key_window > biggest) biggest = key_window;
        if (timeout > biggest) biggest = timeout;
        return lock_clog2(biggest);
    endfunction

endpackage

// File: rtl/rggen_lock_timer.sv
// Loadable down-counter that saturates at zero; reports when it is empty.
module rggen_lock_timer #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_value,
    input  logic          i_enable,
    output logic          o_zero
);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_value;
        end else if (i_enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/rggen_bit_field_lock_controller.sv
// Key-sequence lock controller: KEY_0 then KEY_1 within a window unlocks,
// and any write, a timeout or a hardware request relocks.
module rggen_bit_field_lock_controller
    import rggen_bit_field_lock_controller_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] KEY_0      = 16'h5A5A,
    parameter logic [WIDTH-1:0] KEY_1      = 16'hA5A5,
    parameter int               KEY_WINDOW = 16,
    parameter int               TIMEOUT    = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit_field_valid,
    input  logic [WIDTH-1:0] i_bit_field_read_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_data,
    output logic [WIDTH-1:0] o_bit_field_read_data,
    output logic [WIDTH-1:0] o_bit_field_value,
    input  logic             i_force_lock,
    output logic             o_lock,
    output logic [1:0]       o_state
);

    localparam int            CW           = lock_counter_width(KEY_WINDOW, TIMEOUT);
    localparam logic [CW-1:0] WINDOW_LOAD  = CW'(KEY_WINDOW - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    lock_state_e   state;
    lock_state_e   state_next;
    logic          lock;
    logic          wr;
    logic          full_wr;
    logic          key_0_hit;
    logic          key_1_hit;
    logic          timer_load;
    logic [CW-1:0] timer_load_value;
    logic          timer_enable;
    logic          timer_zero;
    logic          unused_read_mask;

    // Reads carry no side effects, so the read mask has no influence.
    assign unused_read_mask = ^i_bit_field_read_mask;

    assign wr        = i_bit_field_valid && (|i_bit_field_write_mask);
    assign full_wr   = i_bit_field_valid && (&i_bit_field_write_mask);
    assign key_0_hit = full_wr && (i_bit_field_write_data == KEY_0);
    assign key_1_hit = full_wr && (i_bit_field_write_data == KEY_1);

    always_comb begin
        state_next       = state;
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_enable     = 1'b0;
        if (i_force_lock) begin
            state_next = LOCK_LOCKED;
        end else begin
            case (state)
                LOCK_LOCKED: begin
                    if (key_0_hit) begin
                        state_next       = LOCK_ARMED;
                        timer_load       = 1'b1;
                        timer_load_value = WINDOW_LOAD;
                    end
                end
                LOCK_ARMED: begin
                    // KEY_1 is checked before expiry so a write on the last window cycle wins.
                    if (key_1_hit) begin
                        state_next       = LOCK_UNLOCKED;
                        timer_load       = 1'b1;
                        timer_load_value = TIMEOUT_LOAD;
                    end else if (wr || timer_zero) begin
                        state_next = LOCK_LOCKED;
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
                LOCK_UNLOCKED: begin
                    if (wr || ((TIMEOUT != 0) && timer_zero)) begin
                        state_next = LOCK_LOCKED;
                    end else begin
                        timer_enable = (TIMEOUT != 0);
                    end
                end
                default: begin
                    state_next = LOCK_LOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= LOCK_LOCKED;
            lock  <= 1'b1;
        end else begin
            state <= state_next;
            lock  <= (state_next != LOCK_UNLOCKED);
        end
    end

    rggen_lock_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (timer_load),
        .i_load_value (timer_load_value),
        .i_enable     (timer_enable),
        .o_zero       (timer_zero)
    );

    assign o_lock                = lock;
    assign o_state               = state;
    assign o_bit_field_value     = {{(WIDTH-2){1'b0}}, state};
    assign o_bit_field_read_data = o_bit_field_value;

endmodule

// File: tb/tb_rggen_bit_field_lock_controller.sv
// Directed bench for the lock controller; a second instance with TIMEOUT=0
// shares the same stimulus to cover the no-auto-relock configuration.
module tb_rggen_bit_field_lock_controller;

    localparam logic [15:0] K0   = 16'h5A5A;
    localparam logic [15:0] K1   = 16'hA5A5;
    localparam logic [15:0] FULL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        force_lock = 1'b0;
    logic [15:0] read_mask = 16'hFFFF;
    logic [15:0] write_mask = 16'h0000;
    logic [15:0] write_data = 16'h0000;

    logic [15:0] read_data;
    logic [15:0] value;
    logic        lock;
    logic [1:0]  state;
    logic [15:0] nt_read_data;
    logic [15:0] nt_value;
    logic        nt_lock;
    logic [1:0]  nt_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rggen_bit_field_lock_controller dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_bit_field_valid      (valid),
        .i_bit_field_read_mask  (read_mask),
        .i_bit_field_write_mask (write_mask),
        .i_bit_field_write_data (write_data),
        .o_bit_field_read_data  (read_data),
        .o_bit_field_value      (value),
        .i_force_lock           (force_lock),
        .o_lock                 (lock),
        .o_state                (state)
    );

    rggen_bit_field_lock_controller #(
        .TIMEOUT (0)
    ) dut_nt (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_bit_field_valid      (valid),
        .i_bit_field_read_mask  (read_mask),
        .i_bit_field_write_mask (write_mask),
        .i_bit_field_write_data (write_data),
        .o_bit_field_read_data  (nt_read_data),
        .o_bit_field_value      (nt_value),
        .i_force_lock           (force_lock),
        .o_lock                 (nt_lock),
        .o_state                (nt_state)
    );

    task automatic drive_write(input logic [15:0] data, input logic [15:0] mask);
        @(negedge clk);
        valid = 1'b1; write_mask = mask; write_data = data;
        @(posedge clk); #1;
        valid = 1'b0; write_mask = 16'h0000; write_data = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_force();
        @(negedge clk);
        force_lock = 1'b1;
        @(posedge clk); #1;
        force_lock = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic unlock_seq();
        drive_write(K0, FULL);
        idle(2);
        drive_write(K1, FULL);
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL reset_lock got %b want 1", lock); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_read got %h want 0000", read_data); end
        checks++; if (nt_lock !== 1'b1) begin errors++; $display("FAIL reset_nt_lock got %b want 1", nt_lock); end
        @(negedge clk); rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_unlock();
        drive_write(K0, FULL);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL armed_state got %b want 01", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL armed_lock got %b want 1", lock); end
        checks++; if (read_data !== 16'h0001) begin errors++; $display("FAIL armed_read got %h want 0001", read_data); end
        idle(2);
        drive_write(K1, FULL);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL unlock_state got %b want 10", state); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL unlock_lock got %b want 0", lock); end
        checks++; if (read_data !== 16'h0002) begin errors++; $display("FAIL unlock_read got %h want 0002", read_data); end
        checks++; if (value !== 16'h0002) begin errors++; $display("FAIL unlock_value got %h want 0002", value); end
        drive_write(K0, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL unlock_wr_relock got %b want 00", state); end
    endtask

    task automatic test_wrong_key();
        drive_write(K0, FULL);
        drive_write(16'h1234, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL wrong_key_state got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL wrong_key_lock got %b want 1", lock); end
        drive_write(K1, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL lone_key1_state got %b want 00", state); end
        drive_write(K0, FULL);
        drive_write(K0, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL repeat_key0_state got %b want 00", state); end
    endtask

    task automatic test_window();
        // KEY_1 sixteen edges after KEY_0: the counter is exactly zero, write wins.
        drive_write(K0, FULL);
        idle(15);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL window_still_armed got %b want 01", state); end
        drive_write(K1, FULL);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL window_last_state got %b want 10", state); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL window_last_lock got %b want 0", lock); end
        drive_write(16'h0000, FULL);
        // One edge later the window has closed.
        drive_write(K0, FULL);
        idle(16);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL window_expired got %b want 00", state); end
        drive_write(K1, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL window_late_key1 got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL window_late_lock got %b want 1", lock); end
    endtask

    task automatic test_timeout();
        unlock_seq();
        idle(255);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL timeout_before got %b want 10", state); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL timeout_before_lock got %b want 0", lock); end
        idle(1);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL timeout_expired got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL timeout_expired_lock got %b want 1", lock); end
        idle(10000 - 256);
        checks++; if (nt_state !== 2'b10) begin errors++; $display("FAIL no_timeout_state got %b want 10", nt_state); end
        checks++; if (nt_lock !== 1'b0) begin errors++; $display("FAIL no_timeout_lock got %b want 0", nt_lock); end
        drive_write(16'h0000, FULL);
        checks++; if (nt_state !== 2'b00) begin errors++; $display("FAIL no_timeout_wr_relock got %b want 00", nt_state); end
    endtask

    task automatic test_relock();
        unlock_seq();
        @(negedge clk); valid = 1'b1; write_mask = 16'h0000;
        @(posedge clk); #1; valid = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL read_only_keeps got %b want 10", state); end
        drive_write(K1, 16'h00FF);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL partial_unlocked got %b want 00", state); end
        drive_write(K0, FULL);
        drive_write(K1, 16'h00FF);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL partial_armed got %b want 00", state); end
        drive_write(K0, FULL);
        pulse_force();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL force_armed got %b want 00", state); end
        unlock_seq();
        pulse_force();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL force_unlocked got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL force_unlocked_lock got %b want 1", lock); end
        drive_write(K0, FULL);
        @(negedge clk);
        valid = 1'b1; write_mask = FULL; write_data = K1; force_lock = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; write_mask = 16'h0000; write_data = 16'h0000; force_lock = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL force_with_key1 got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL force_with_key1_lock got %b want 1", lock); end
    endtask

    task automatic test_reset_mid();
        drive_write(K0, FULL);
        pulse_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_armed_state got %b want 00", state); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL rst_armed_read got %h want 0000", read_data); end
        drive_write(K1, FULL);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_armed_key1 got %b want 00", state); end
        unlock_seq();
        pulse_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_unlocked_state got %b want 00", state); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL rst_unlocked_lock got %b want 1", lock); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL rst_unlocked_read got %h want 0000", read_data); end
        drive_write(K1, FULL);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL rst_unlocked_key1 got %b want 1", lock); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_key();
        test_window();
        test_timeout();
        test_relock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
